// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// a registered read port with valid strobe, and sticky overflow/underflow flags.
module sync_fifo_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_req,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     rd_req,
  output logic [WIDTH-1:0]         data_out,
  output logic                     data_valid,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_empty,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] AF_TH = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_TH = CW'(AE_LEVEL);

  logic [WIDTH-1:0] r_mem [DEPTH];

  logic [CW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_rd_ptr;
  logic [WIDTH-1:0] r_data_out;
  logic             r_data_valid;
  logic             r_overflow;
  logic             r_underflow;

  logic [AW-1:0]    w_wr_addr;
  logic [AW-1:0]    w_rd_addr;
  logic [CW-1:0]    w_count;
  logic             w_full;
  logic             w_empty;
  logic             w_wr_acc;
  logic             w_rd_acc;

  assign w_wr_addr = r_wr_ptr[AW-1:0];
  assign w_rd_addr = r_rd_ptr[AW-1:0];

  // Status is a pure function of the registered pointers, so no request
  // input ever reaches an output combinationally.
  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (w_wr_addr == w_rd_addr) && (r_wr_ptr[AW] != r_rd_ptr[AW]);

  assign w_wr_acc = wr_req && !w_full && !rst;
  assign w_rd_acc = rd_req && !w_empty && !rst;

  // Storage carries no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[w_wr_addr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      r_data_valid <= w_rd_acc;
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_acc) begin
        r_rd_ptr   <= r_rd_ptr + 1'b1;
        r_data_out <= r_mem[w_rd_addr];
      end
      if (wr_req && w_full) begin
        r_overflow <= 1'b1;
      end
      if (rd_req && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign data_out     = r_data_out;
  assign data_valid   = r_data_valid;
  assign empty        = w_empty;
  assign full         = w_full;
  assign count        = w_count;
  assign almost_full  = (w_count >= AF_TH);
  assign almost_empty = (w_count <= AE_TH);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed and random stimulus for sync_fifo_param, checked every cycle
// against a queue-based reference model.
module tb_sync_fifo_param;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr_req = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic             rd_req = 1'b0;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             empty;
  logic             full;
  logic             almost_empty;
  logic             almost_full;
  logic [$clog2(DEPTH):0] count;
  logic             overflow;
  logic             underflow;

  int n_total = 0;
  int n_pass  = 0;

  // reference model state
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] exp_dout = '0;
  logic             exp_dv   = 1'b0;
  logic             exp_ovf  = 1'b0;
  logic             exp_unf  = 1'b0;

  sync_fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .rst(rst), .wr_req(wr_req), .data_in(data_in), .rd_req(rd_req),
    .data_out(data_out), .data_valid(data_valid), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".count"},     32'(count),        32'(q.size()));
    chk({ctx, ".empty"},     32'(empty),        32'(q.size() == 0));
    chk({ctx, ".full"},      32'(full),         32'(q.size() == DEPTH));
    chk({ctx, ".aempty"},    32'(almost_empty), 32'(q.size() <= AE));
    chk({ctx, ".afull"},     32'(almost_full),  32'(q.size() >= AF));
    chk({ctx, ".valid"},     32'(data_valid),   32'(exp_dv));
    chk({ctx, ".dout"},      32'(data_out),     32'(exp_dout));
    chk({ctx, ".overflow"},  32'(overflow),     32'(exp_ovf));
    chk({ctx, ".underflow"}, 32'(underflow),    32'(exp_unf));
  endtask

  // One clock: drive requests, let the edge happen, advance the model, compare.
  task automatic step(input string ctx, input logic rs, input logic w,
                      input logic [WIDTH-1:0] d, input logic r);
    bit was_full, was_empty;
    rst = rs; wr_req = w; data_in = d; rd_req = r;
    @(posedge clk);
    #1;
    if (rs) begin
      q.delete();
      exp_dout = '0; exp_dv = 1'b0; exp_ovf = 1'b0; exp_unf = 1'b0;
    end else begin
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      exp_dv = 1'b0;
      if (r && !was_empty) begin
        exp_dout = q.pop_front();
        exp_dv   = 1'b1;
      end
      if (w && !was_full) q.push_back(d);
      if (w && was_full)  exp_ovf = 1'b1;
      if (r && was_empty) exp_unf = 1'b1;
    end
    check_all(ctx);
    $display("t=%0t %s rst=%0b wr=%0b din=%02h rd=%0b -> cnt=%0d dv=%0b dout=%02h ovf=%0b unf=%0b",
             $time, ctx, rs, w, d, r, count, data_valid, data_out, overflow, underflow);
  endtask

  initial begin
    logic [WIDTH-1:0] seq;

    // reset then idle
    step("reset", 1'b1, 1'b0, 8'h00, 1'b0);
    step("reset", 1'b1, 1'b1, 8'h33, 1'b1);
    step("idle",  1'b0, 1'b0, 8'h00, 1'b0);

    // fill 0x00..0x0F, then drain in order
    for (int i = 0; i < DEPTH; i++) step("fill", 1'b0, 1'b1, WIDTH'(i), 1'b0);
    chk("filled.count", 32'(count), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      step("drain", 1'b0, 1'b0, 8'h00, 1'b1);
      chk("drain.order", 32'(data_out), 32'(i));
    end

    // full with both requests: read wins, write rejected, overflow sticky
    for (int i = 0; i < DEPTH; i++) step("refill", 1'b0, 1'b1, WIDTH'(8'h40 + i), 1'b0);
    step("full_both", 1'b0, 1'b1, 8'hEE, 1'b1);
    chk("full_both.count", 32'(count), 32'(DEPTH - 1));
    chk("full_both.oldest", 32'(data_out), 32'h40);
    for (int i = 0; i < DEPTH - 1; i++) step("drain2", 1'b0, 1'b0, 8'h00, 1'b1);

    // empty with both requests: write wins, read rejected, underflow sticky
    step("empty_both", 1'b0, 1'b1, 8'hA5, 1'b1);
    chk("empty_both.count", 32'(count), 32'd1);
    chk("empty_both.valid", 32'(data_valid), 32'd0);
    step("read_a5", 1'b0, 1'b0, 8'h00, 1'b1);
    chk("read_a5.dout", 32'(data_out), 32'hA5);

    // wrap: clear flags, hold count at 8 for 40 simultaneous cycles
    step("rst2", 1'b1, 1'b0, 8'h00, 1'b0);
    seq = 8'h00;
    for (int i = 0; i < 8; i++) begin step("pre", 1'b0, 1'b1, seq, 1'b0); seq++; end
    for (int i = 0; i < 40; i++) begin step("wrap", 1'b0, 1'b1, seq, 1'b1); seq++; end
    chk("wrap.count", 32'(count), 32'd8);
    chk("wrap.last", 32'(data_out), 32'd39);
    chk("wrap.ovf", 32'(overflow), 32'd0);
    chk("wrap.unf", 32'(underflow), 32'd0);

    // random traffic
    for (int i = 0; i < 400; i++)
      step("rand", 1'b0, 1'($urandom_range(0, 1)), WIDTH'($urandom), 1'($urandom_range(0, 1)));

    // reset mid-operation at count 5 with requests asserted
    step("rst3", 1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) step("pre5", 1'b0, 1'b1, WIDTH'(8'h10 + i), 1'b0);
    step("mid_rst", 1'b1, 1'b1, 8'h77, 1'b1);
    chk("mid_rst.count", 32'(count), 32'd0);
    chk("mid_rst.empty", 32'(empty), 32'd1);
    step("post_wr", 1'b0, 1'b1, 8'h5C, 1'b0);
    step("post_rd", 1'b0, 1'b0, 8'h00, 1'b1);
    chk("post_rd.dout", 32'(data_out), 32'h5C);
    step("post_idle", 1'b0, 1'b0, 8'h00, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
